// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: decode-stage issue controller.
// Two-entry skid buffer between fetch and EX with load-use hazard
// detection, front-end flush, immediate-format select and an illegal
// opcode flag for the head instruction.
module decode_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [2:0]  id_imm_fmt,
    output logic        id_illegal,
    output logic [15:0] stall_cycles
);

    // Occupancy doubles as the controller state.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } slot_t;

    logic [1:0]  count_q, count_d;
    slot_t       slot0_q, slot0_d;
    slot_t       slot1_q, slot1_d;
    logic [15:0] stall_q, stall_d;

    logic        head_vld;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic        rs1_use, rs2_use, legal;
    logic [2:0]  fmt;
    logic        hazard, push, pop;
    slot_t       in_slot;

    assign head_vld = (count_q != ST_EMPTY);
    assign opcode   = slot0_q.instr[6:0];
    assign rs1      = slot0_q.instr[19:15];
    assign rs2      = slot0_q.instr[24:20];
    assign in_slot  = '{instr: if_instr, pc: if_pc};

    // Decode register usage, immediate format and legality of the head opcode.
    always_comb begin
        rs1_use = 1'b0;
        rs2_use = 1'b0;
        legal   = 1'b1;
        fmt     = FMT_NONE;
        case (opcode)
            OP_ALU:    begin rs1_use = 1'b1; rs2_use = 1'b1; end
            OP_ALUI:   begin rs1_use = 1'b1; fmt = FMT_I; end
            OP_LOAD:   begin rs1_use = 1'b1; fmt = FMT_I; end
            OP_STORE:  begin rs1_use = 1'b1; rs2_use = 1'b1; fmt = FMT_S; end
            OP_BRANCH: begin rs1_use = 1'b1; rs2_use = 1'b1; fmt = FMT_B; end
            OP_JALR:   begin rs1_use = 1'b1; fmt = FMT_I; end
            OP_JAL:    fmt = FMT_J;
            OP_LUI:    fmt = FMT_U;
            OP_AUIPC:  fmt = FMT_U;
            OP_SYSTEM: fmt = FMT_I;
            default:   legal = 1'b0;
        endcase
    end

    // Load-use hazard against EX, and the fetch/issue handshakes.
    always_comb begin
        hazard = head_vld & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                 ((rs1_use & (rs1 == ex_rd)) | (rs2_use & (rs2 == ex_rd)));
        // if_ready comes from registered occupancy only, keeping fetch off
        // the EX-side combinational paths.
        if_ready   = (count_q != ST_TWO);
        id_valid   = head_vld & ~hazard & ~flush;
        push       = if_valid & if_ready & ~flush;
        pop        = id_valid & id_ready;
        id_instr   = slot0_q.instr;
        id_pc      = slot0_q.pc;
        // Stale slot contents after draining must not look like a live format.
        id_imm_fmt = head_vld ? fmt : FMT_NONE;
        id_illegal = head_vld & ~legal;
    end

    // Buffer next state: flush empties; otherwise push/pop per occupancy.
    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (flush) begin
            count_d = ST_EMPTY;
        end else begin
            case (count_q)
                ST_EMPTY: begin
                    if (push) begin
                        slot0_d = in_slot;
                        count_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            slot1_d = in_slot;
                            count_d = ST_TWO;
                        end
                        2'b01:   count_d = ST_EMPTY;
                        2'b11:   slot0_d = in_slot;
                        default: count_d = ST_ONE;
                    endcase
                end
                ST_TWO: begin
                    if (pop) begin
                        slot0_d = slot1_q;
                        count_d = ST_ONE;
                    end
                end
                default: count_d = ST_EMPTY;
            endcase
        end
    end

    // Saturating bubble counter; survives flush.
    always_comb begin
        stall_d = stall_q;
        if (hazard && !flush && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= ST_EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
            stall_q <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed self-checking bench for decode_issue_ctrl.
module tb_decode_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [2:0]  id_imm_fmt;
    logic        id_illegal;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;

    decode_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_imm_fmt(id_imm_fmt), .id_illegal(id_illegal), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_if(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_if(1'b0, 32'h0, 32'h0);
        flush = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0; id_ready = 0;
        #12;
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL reset_if_ready got=%0b exp=1", if_ready); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
        total++; if (id_illegal !== 1'b0 || id_imm_fmt !== 3'd0) begin bad++; $display("FAIL reset_decode got ill=%0b fmt=%0d exp 0/0", id_illegal, id_imm_fmt); end
        total++; if (id_instr !== 32'h0 || id_pc !== 32'h0) begin bad++; $display("FAIL reset_head got instr=%h pc=%h exp 0/0", id_instr, id_pc); end
        total++; if (stall_cycles !== 16'h0) begin bad++; $display("FAIL reset_stall got=%h exp=0", stall_cycles); end
        rst_n = 1'b1;
        exp_stall = 0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] exp_pc;
        id_ready = 1'b1;
        drive_if(1'b1, 32'h00500093, 32'h100);
        tick();
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        total++; if (id_valid !== 1'b1 || id_imm_fmt !== 3'd1 || id_pc !== 32'h100 || id_instr !== 32'h00500093)
            begin bad++; $display("FAIL basic_first got v=%0b fmt=%0d pc=%h ins=%h exp 1/1/100/00500093", id_valid, id_imm_fmt, id_pc, id_instr); end
        // Stream 8 ADDIs while the head pops each cycle.
        for (int i = 0; i < 8; i++) begin
            drive_if(1'b1, 32'h00000093 | (32'(i) << 20), 32'h200 + 32'(4 * i));
            #1;
            exp_pc = (i == 0) ? 32'h100 : 32'h200 + 32'(4 * (i - 1));
            total++; if (id_valid !== 1'b1 || id_pc !== exp_pc || if_ready !== 1'b1)
                begin bad++; $display("FAIL basic_stream%0d got v=%0b pc=%h rdy=%0b exp 1/%h/1", i, id_valid, id_pc, if_ready, exp_pc); end
            tick();
        end
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h21C || id_instr !== 32'h00700093)
            begin bad++; $display("FAIL basic_last got v=%0b pc=%h ins=%h exp 1/21c/00700093", id_valid, id_pc, id_instr); end
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got v=%0b exp=0", id_valid); end
    endtask

    task automatic test_backpressure();
        id_ready = 1'b0;
        drive_if(1'b1, 32'h00100113, 32'h300);
        tick();
        drive_if(1'b1, 32'h00200113, 32'h304);
        tick();
        drive_if(1'b1, 32'h00300113, 32'h308);
        #1;
        total++; if (if_ready !== 1'b0 || id_pc !== 32'h300)
            begin bad++; $display("FAIL bp_full got rdy=%0b pc=%h exp 0/300", if_ready, id_pc); end
        tick();
        total++; if (if_ready !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h300)
            begin bad++; $display("FAIL bp_hold got rdy=%0b v=%0b pc=%h exp 0/1/300", if_ready, id_valid, id_pc); end
        id_ready = 1'b1;
        tick();
        total++; if (if_ready !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h304)
            begin bad++; $display("FAIL bp_second got rdy=%0b v=%0b pc=%h exp 1/1/304", if_ready, id_valid, id_pc); end
        tick();
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h308 || id_instr !== 32'h00300113)
            begin bad++; $display("FAIL bp_third got v=%0b pc=%h ins=%h exp 1/308/00300113", id_valid, id_pc, id_instr); end
        tick();
        total++; if (id_valid !== 1'b0 || if_ready !== 1'b1)
            begin bad++; $display("FAIL bp_empty got v=%0b rdy=%0b exp 0/1", id_valid, if_ready); end
    endtask

    task automatic test_load_use();
        id_ready = 1'b1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        drive_if(1'b1, 32'h00728333, 32'h400);   // ADD x6,x5,x7
        tick();
        drive_if(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (id_valid !== 1'b0 || stall_cycles !== 16'(exp_stall))
                begin bad++; $display("FAIL lu_stall%0d got v=%0b st=%0d exp 0/%0d", i, id_valid, stall_cycles, exp_stall); end
            tick();
            exp_stall++;
        end
        ex_valid = 1'b0;
        #1;
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h400 || stall_cycles !== 16'(exp_stall))
            begin bad++; $display("FAIL lu_release got v=%0b pc=%h st=%0d exp 1/400/%0d", id_valid, id_pc, stall_cycles, exp_stall); end
        tick();
        // rs2 dependence also stalls.
        ex_valid = 1'b1; ex_rd = 5'd7;
        drive_if(1'b1, 32'h00700333, 32'h404);   // ADD x6,x0,x7
        tick();
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL lu_rs2 got v=%0b exp 0", id_valid); end
        tick();
        exp_stall++;
        // ex_rd = x0 never stalls, even though the head reads x0.
        ex_rd = 5'd0;
        #1;
        total++; if (id_valid !== 1'b1 || stall_cycles !== 16'(exp_stall))
            begin bad++; $display("FAIL lu_x0 got v=%0b st=%0d exp 1/%0d", id_valid, stall_cycles, exp_stall); end
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0;
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        drive_if(1'b1, 32'h00100193, 32'h500);
        tick();
        drive_if(1'b1, 32'h00200193, 32'h504);
        tick();
        drive_if(1'b1, 32'h00300193, 32'h508);
        id_ready = 1'b1;
        flush = 1'b1;
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL fl_full_valid got=%0b exp 0", id_valid); end
        tick();
        flush = 1'b0;
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        total++; if (id_valid !== 1'b0 || if_ready !== 1'b1)
            begin bad++; $display("FAIL fl_empty got v=%0b rdy=%0b exp 0/1", id_valid, if_ready); end
        // Flush with one buffered and a concurrent push: both dropped.
        id_ready = 1'b0;
        drive_if(1'b1, 32'h00400193, 32'h50C);
        tick();
        drive_if(1'b1, 32'h00500193, 32'h510);
        flush = 1'b1; id_ready = 1'b1;
        tick();
        flush = 1'b0;
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL fl_push_drop got v=%0b exp 0", id_valid); end
        drive_if(1'b1, 32'h00600193, 32'h514);
        tick();
        drive_if(1'b0, 32'h0, 32'h0);
        #1;
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h514)
            begin bad++; $display("FAIL fl_refill got v=%0b pc=%h exp 1/514", id_valid, id_pc); end
        tick();
    endtask

    task automatic test_imm_fmt();
        logic [31:0] words [5];
        logic [2:0]  fmts  [5];
        logic        ills  [5];
        words = '{32'h0020a023, 32'h00208063, 32'h000012b7, 32'h008000ef, 32'h0000007F};
        fmts  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        ills  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        id_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_if(1'b1, words[i], 32'h600 + 32'(4 * i));
            tick();
            drive_if(1'b0, 32'h0, 32'h0);
            #1;
            total++; if (id_valid !== 1'b1 || id_imm_fmt !== fmts[i] || id_illegal !== ills[i])
                begin bad++; $display("FAIL fmt%0d got v=%0b fmt=%0d ill=%0b exp 1/%0d/%0b", i, id_valid, id_imm_fmt, id_illegal, fmts[i], ills[i]); end
            tick();
        end
    endtask

    task automatic test_saturation();
        id_ready = 1'b1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        drive_if(1'b1, 32'h00728333, 32'h700);
        tick();
        drive_if(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        exp_stall = (exp_stall + 70000 > 65535) ? 65535 : exp_stall + 70000;
        total++; if (stall_cycles !== 16'(exp_stall) || id_valid !== 1'b0)
            begin bad++; $display("FAIL sat got st=%h v=%0b exp %h/0", stall_cycles, id_valid, exp_stall); end
        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (stall_cycles !== 16'h0 || if_ready !== 1'b1 || id_valid !== 1'b0 ||
                     id_pc !== 32'h0 || id_instr !== 32'h0 || id_imm_fmt !== 3'd0 || id_illegal !== 1'b0)
            begin bad++; $display("FAIL async_rst got st=%h rdy=%0b v=%0b pc=%h ins=%h fmt=%0d ill=%0b exp all reset", stall_cycles, if_ready, id_valid, id_pc, id_instr, id_imm_fmt, id_illegal); end
        ex_valid = 1'b0; ex_is_load = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        total++; if (if_ready !== 1'b1 || id_valid !== 1'b0)
            begin bad++; $display("FAIL post_rst got rdy=%0b v=%0b exp 1/0", if_ready, id_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_load_use();
        test_flush();
        test_imm_fmt();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Decode-stage issue controller between instruction fetch and execute. It buffers fetched instructions in a 2-entry skid buffer and detects load-use hazards against the instruction in EX, inserting bubbles when needed. It applies front-end flushes and issues each instruction to EX over a valid/ready handshake. It also drives the immediate-format select that configures the decode immediate generator for the instruction being issued.

## Interface
- Parameters: none; all widths fixed by RV32I.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  controller can accept; equals (count < 2)
- if_instr  in  32  fetched instruction word
- if_pc  in  32  PC of fetched instruction
- flush  in  1  redirect from EX; discards all buffered and incoming instructions
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  destination register of EX instruction
- id_valid  out  1  instruction offered to EX
- id_ready  in  1  EX accepts the offered instruction
- id_instr  out  32  head instruction word
- id_pc  out  32  head PC
- id_imm_fmt  out  3  immediate select: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
- id_illegal  out  1  head opcode not a recognised RV32I opcode
- stall_cycles  out  16  saturating count of load-use bubble cycles

## Operation
- Storage: two slots, slot0 = head, plus a 2-bit count (0, 1, 2). State is EMPTY/ONE/TWO by count; no other states.
- Push: if_valid & if_ready & !flush. The new word goes to slot[count], or to slot[count-1] when a pop happens in the same cycle.
- Pop: id_valid & id_ready. slot1 shifts into slot0.
- Transitions:
  - EMPTY: push → ONE.
  - ONE: push only → TWO; pop only → EMPTY; push+pop → ONE.
  - TWO: pop → ONE. Push is impossible because if_ready=0.
- Flush: count←0 at the next edge, whatever the push/pop/hazard state. Slot contents are don't-care.
- Register usage is decoded from head opcode [6:0]:
  - rs1 (bits 19:15) used by ALU 0110011, ALUI 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111.
  - rs2 (bits 24:20) used by ALU, STORE, BRANCH.
- Hazard = count>0 & ex_valid & ex_is_load & ex_rd≠0 & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)).
- id_valid = (count>0) & !hazard & !flush.
- id_imm_fmt from head opcode:
  - I: ALUI, LOAD, JALR, SYSTEM 1110011
  - S: STORE
  - B: BRANCH
  - U: LUI 0110111, AUIPC 0010111
  - J: JAL 1101111
  - NONE: ALU and everything else.
- id_illegal = count>0 & opcode not in {ALU, ALUI, LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC, SYSTEM}. Illegal instructions still issue normally; EX raises the trap.
- stall_cycles increments by 1 each cycle hazard=1 & !flush. It saturates at 0xFFFF with no wrap and is not cleared by flush.

## Timing
- Reset values (asynchronous on rst_n=0):
  - count=0, stall_cycles=0
  - if_ready=1, id_valid=0, id_illegal=0, id_imm_fmt=0
  - id_instr/id_pc = 0
- Latency: a word pushed at edge N is presented on id_* during cycle N+1. The minimum fetch-to-issue latency is 1 cycle.
- Throughput: 1 instruction/cycle sustained while id_ready=1 and no hazard.
- if_ready depends only on registered count, never combinationally on id_ready, flush or hazard.
- id_* are combinational from slot0 plus the EX inputs. Once id_valid=1, id_instr/id_pc stay stable until a pop or flush.
- A hazard holds the head for as many cycles as it persists. There is no internal timeout; EX advancing clears it.
- Simultaneous flush and push: the incoming word is dropped. Simultaneous flush and id_ready: no pop is counted.
- rst_n asserted mid-operation: all buffered instructions are lost immediately. if_ready=1 on the first cycle after release.

## Test plan
- Reset/basic: after reset, push ADDI x1,x0,5 (0x00500093) at PC 0x100 with id_ready=1 → next cycle id_valid=1, id_imm_fmt=1, id_pc=0x100. Sustained pushes of 8 instructions issue at 1 per cycle, in order.
- Backpressure: id_ready=0, push 3 instructions → if_ready drops after 2 accepts, count=2, third held by fetch. Then id_ready=1 → the 3 issue in order, no loss or duplication.
- Load-use: EX holds LW x5 (ex_valid=1, ex_is_load=1, ex_rd=5), head ADD x6,x5,x7 → id_valid=0, stall_cycles +1 per cycle. Deassert ex_valid → head issues. Same with ex_rd=0 → no stall.
- Flush: with count=2 and a push in the same cycle, assert flush → id_valid=0 that cycle, count=0 next cycle, the dropped words never issue.
- Imm format/illegal: present SW, BEQ, LUI, JAL, opcode 0x7F → id_imm_fmt = 2, 3, 4, 5, 0; id_illegal=1 only for 0x7F.
- Saturation/reset: force a hazard for 70000 cycles → stall_cycles=0xFFFF. Assert rst_n=0 mid-run → all outputs return to reset values asynchronously.
